// File: rtl/warp_fence_ctrl_pkg.sv
// Shared types for the warp fence controller: per-warp FSM state and settle-counter sizing.
// Default warp-count macros live here so the package and the top agree on them.
`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 3
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package warp_fence_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } fence_state_e;

    function automatic int settle_cnt_w(input int settle_cycles);
        return `CLOG2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/VX_rr_arbiter.sv
// Round-robin arbiter; combinational grant, pointer moves past the winner on handshake.
// A grant left unaccepted is locked so index/valid hold steady until grant_ready.
module VX_rr_arbiter #(
    parameter int NUM_REQS     = 8,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic                    grant_valid,
    input  logic                    grant_ready
);

    logic [LOG_NUM_REQS-1:0] r_ptr;
    logic [LOG_NUM_REQS-1:0] r_lock_idx;
    logic                    r_locked;
    logic [LOG_NUM_REQS-1:0] w_pick;
    logic [LOG_NUM_REQS-1:0] w_cand;
    logic                    w_found;

    // Descending scan so the request closest to the pointer is written last and wins.
    always_comb begin
        w_pick  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            w_cand = LOG_NUM_REQS'((int'(r_ptr) + i) % NUM_REQS);
            if (requests[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign grant_valid  = r_locked | w_found;
    assign grant_index  = r_locked ? r_lock_idx : w_pick;
    assign grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (grant_valid && grant_ready) begin
            r_ptr    <= (grant_index == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant_index + LOG_NUM_REQS'(1);
            r_locked <= 1'b0;
        end else if (grant_valid) begin
            r_locked   <= 1'b1;
            r_lock_idx <= grant_index;
        end
    end

endmodule

// File: rtl/warp_fence_ctrl.sv
// Per-warp fence stall/release controller; stall_mask from T+1, release earliest T+1+SETTLE_CYCLES.
// Busy warps back-pressure new fences; releases hold until rel_ready. FENCE_PERF_EN adds a stall-cycle counter.
`ifndef NUM_WARPS
`define NUM_WARPS 8
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 3
`endif

module warp_fence_ctrl
    import warp_fence_ctrl_pkg::*;
#(
    parameter int WARP_CNT       = `NUM_WARPS,
    parameter int WARP_CNT_WIDTH = `NW_WIDTH,
    parameter int SETTLE_CYCLES  = 2
`ifdef FENCE_PERF_EN
    ,
    parameter int PERF_CTR_BITS  = 44
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fence_valid,
    input  logic [WARP_CNT_WIDTH-1:0] fence_wid,
    output logic                      fence_ready,
    input  logic [WARP_CNT-1:0]       pend_empty,
    output logic [WARP_CNT-1:0]       stall_mask,
    output logic                      rel_valid,
    output logic [WARP_CNT_WIDTH-1:0] rel_wid,
    input  logic                      rel_ready,
    input  logic                      drain_req,
    output logic                      drain_done
`ifdef FENCE_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]  perf_stall_cycles
`endif
);

    localparam int SW = settle_cnt_w(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    logic [WARP_CNT-1:0] w_idle;
    logic [WARP_CNT-1:0] w_done;
    logic [WARP_CNT-1:0] w_busy;
    logic [WARP_CNT-1:0] w_rel_onehot;
    logic                r_drain_done;

    assign fence_ready = fence_valid && w_idle[fence_wid];
    assign stall_mask  = ~w_idle;

    for (genvar g = 0; g < WARP_CNT; g++) begin : g_warp
        fence_state_e r_state;
        fence_state_e w_state_nxt;
        logic [SW-1:0] r_cnt;
        logic [SW-1:0] w_cnt_nxt;
        logic          w_acc;
        logic          w_rel;

        assign w_acc = fence_ready && (fence_wid == WARP_CNT_WIDTH'(g));
        assign w_rel = rel_valid && rel_ready && w_rel_onehot[g];

        // The last settle cycle also samples pend_empty, so DONE is reachable at T+1+SETTLE_CYCLES.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = pend_empty[g] ? ST_DONE : ST_WAIT;
                    end else begin
                        w_cnt_nxt = r_cnt - SW'(1);
                    end
                end
                ST_WAIT: begin
                    if (pend_empty[g]) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_rel) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        assign w_idle[g] = (r_state == ST_IDLE);
        assign w_done[g] = (r_state == ST_DONE);
        assign w_busy[g] = (r_state == ST_SETTLE) || (r_state == ST_WAIT);
    end

    VX_rr_arbiter #(
        .NUM_REQS     (WARP_CNT),
        .LOG_NUM_REQS (WARP_CNT_WIDTH)
    ) u_rel_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (w_done),
        .grant_index  (rel_wid),
        .grant_onehot (w_rel_onehot),
        .grant_valid  (rel_valid),
        .grant_ready  (rel_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= drain_req && (&pend_empty) && !(|w_busy);
        end
    end

    assign drain_done = r_drain_done;

`ifdef FENCE_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall_cycles <= '0;
        end else if (|stall_mask) begin
            r_perf_stall_cycles <= r_perf_stall_cycles + PERF_CTR_BITS'(1);
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_warp_fence_ctrl.sv
// Bench for warp_fence_ctrl: directed scenarios plus random traffic against a cycle-count reference model.
// Expected releases go into a queue that a separate monitor pops on each DUT release handshake.
module tb_warp_fence_ctrl;

    localparam int N  = 8;
    localparam int WW = 3;
    localparam int S  = 2;
    localparam int PB = 44;

    logic          clk;
    logic          reset;
    logic          fence_valid;
    logic [WW-1:0] fence_wid;
    logic          fence_ready;
    logic [N-1:0]  pend_empty;
    logic [N-1:0]  stall_mask;
    logic          rel_valid;
    logic [WW-1:0] rel_wid;
    logic          rel_ready;
    logic          drain_req;
    logic          drain_done;
`ifdef FENCE_PERF_EN
    logic [PB-1:0] perf_stall_cycles;
`endif

    warp_fence_ctrl #(
        .WARP_CNT       (N),
        .WARP_CNT_WIDTH (WW),
        .SETTLE_CYCLES  (S)
`ifdef FENCE_PERF_EN
        ,
        .PERF_CTR_BITS  (PB)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fence_valid (fence_valid),
        .fence_wid   (fence_wid),
        .fence_ready (fence_ready),
        .pend_empty  (pend_empty),
        .stall_mask  (stall_mask),
        .rel_valid   (rel_valid),
        .rel_wid     (rel_wid),
        .rel_ready   (rel_ready),
        .drain_req   (drain_req),
        .drain_done  (drain_done)
`ifdef FENCE_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a warp is "fenced" from acceptance until release, becomes releasable
    // once pend_empty is seen on or after cycle accept+S, and releases go round-robin.
    bit            m_fenced[N];
    bit            m_done[N];
    int            m_earliest[N];
    int            m_ptr;
    bit            m_hold;
    int            m_hold_wid;
    bit            m_drain;
    logic [PB-1:0] m_perf;
    int            cyc = 0;

    bit            exp_vld = 1'b0;
    bit            e_fr;
    logic [N-1:0]  e_stall;
    bit            e_rv;
    int            e_wid;
    int            exp_q[$];
    int            exp_wid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < N; w++) begin
            m_fenced[w]   = 1'b0;
            m_done[w]     = 1'b0;
            m_earliest[w] = 0;
        end
        m_ptr      = 0;
        m_hold     = 1'b0;
        m_hold_wid = 0;
        m_drain    = 1'b0;
        m_perf     = '0;
    endtask

    task automatic model_eval();
        int w;
        e_fr  = fence_valid && !m_fenced[fence_wid];
        e_rv  = 1'b0;
        e_wid = 0;
        for (int k = 0; k < N; k++) e_stall[k] = m_fenced[k];
        if (m_hold) begin
            e_rv  = 1'b1;
            e_wid = m_hold_wid;
        end else begin
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (!e_rv && m_fenced[w] && m_done[w]) begin
                    e_rv  = 1'b1;
                    e_wid = w;
                end
            end
        end
        if (e_rv && rel_ready) exp_q.push_back(e_wid);
    endtask

    task automatic model_step();
        bit busy;
        busy = 1'b0;
        for (int w = 0; w < N; w++) if (m_fenced[w] && !m_done[w]) busy = 1'b1;
        m_drain = drain_req && (&pend_empty) && !busy;
        if (|e_stall) m_perf = m_perf + 1;
        if (e_rv && rel_ready) begin
            m_fenced[e_wid] = 1'b0;
            m_done[e_wid]   = 1'b0;
            m_ptr           = (e_wid + 1) % N;
            m_hold          = 1'b0;
        end else if (e_rv) begin
            m_hold     = 1'b1;
            m_hold_wid = e_wid;
        end
        for (int w = 0; w < N; w++)
            if (m_fenced[w] && !m_done[w] && cyc >= m_earliest[w] && pend_empty[w]) m_done[w] = 1'b1;
        if (e_fr) begin
            m_fenced[fence_wid]   = 1'b1;
            m_done[fence_wid]     = 1'b0;
            m_earliest[fence_wid] = cyc + S;
        end
        cyc++;
    endtask

    always @(posedge clk) begin
        if (exp_vld && !reset) model_step();
    end

    // Monitor: compares every cycle's outputs and pops the scoreboard on each release handshake.
    always @(negedge clk) begin
        #2;
        if (exp_vld && !reset) begin
            chk("fence_ready", fence_ready, e_fr);
            chk("stall_mask", stall_mask, e_stall);
            chk("rel_valid", rel_valid, e_rv);
            chk("drain_done", drain_done, m_drain);
`ifdef FENCE_PERF_EN
            chk("perf_stall_cycles", perf_stall_cycles, m_perf);
`endif
            if (rel_valid === 1'b1 && rel_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rel_unexpected: release of warp %0d, no release expected (t=%0t)", rel_wid, $time);
                end else begin
                    exp_wid = exp_q.pop_front();
                    chk("rel_wid", rel_wid, exp_wid);
                end
            end
        end
    end

    task automatic step(input bit fv, input int fw, input logic [N-1:0] pe, input bit rr, input bit dr);
        @(negedge clk);
        fence_valid = fv;
        fence_wid   = WW'(fw);
        pend_empty  = pe;
        rel_ready   = rr;
        drain_req   = dr;
        model_eval();
        exp_vld = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        exp_vld     = 1'b0;
        fence_valid = 1'b0;
        rel_ready   = 1'b0;
        drain_req   = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("async_rst stall_mask", stall_mask, 0);
        chk("async_rst rel_valid", rel_valid, 0);
        chk("async_rst drain_done", drain_done, 0);
`ifdef FENCE_PERF_EN
        chk("async_rst perf", perf_stall_cycles, 0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[3];
        ord = '{0, 2, 5};
        reset       = 1'b0;
        fence_valid = 1'b0;
        fence_wid   = '0;
        pend_empty  = '1;
        rel_ready   = 1'b0;
        drain_req   = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2;
        chk("reset stall_mask", stall_mask, 0);
        chk("reset rel_valid", rel_valid, 0);
        chk("reset rel_wid", rel_wid, 0);
        chk("reset fence_ready", fence_ready, 0);
        chk("reset drain_done", drain_done, 0);
`ifdef FENCE_PERF_EN
        chk("reset perf", perf_stall_cycles, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Warp 3, everything drained: release at T+3, unstalled at T+4.
        step(1, 3, 8'hFF, 1, 0); #3 chk("w3 fence_ready T", fence_ready, 1);
        step(0, 0, 8'hFF, 1, 0); #3 chk("w3 stall_mask T+1", stall_mask, 8'h08);
        step(0, 0, 8'hFF, 1, 0); #3 chk("w3 rel_valid T+2", rel_valid, 0);
        step(0, 0, 8'hFF, 1, 0); #3 chk("w3 rel_valid T+3", rel_valid, 1);
        chk("w3 rel_wid T+3", rel_wid, 3);
        step(0, 0, 8'hFF, 1, 0); #3 chk("w3 stall_mask T+4", stall_mask, 0);

        // Warp 1 held in WAIT, re-fence back-pressured until the cycle after release.
        step(1, 1, 8'hFD, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 8'hFD, 1, 0); #3 chk("w1 refence blocked", fence_ready, 0);
        end
        chk("w1 still waiting", rel_valid, 0);
        step(1, 1, 8'hFF, 1, 0);
        step(1, 1, 8'hFF, 1, 0); #3 chk("w1 rel_valid", rel_valid, 1);
        chk("w1 fence vs release", fence_ready, 0);
        step(1, 1, 8'hFF, 1, 0); #3 chk("w1 refence accepted", fence_ready, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'hFF, 1, 0);

        do_reset();

        // Warps 0, 2, 5 reach DONE together; rel_ready withheld for 3 cycles.
        step(1, 0, 8'hDA, 0, 0);
        step(1, 2, 8'hDA, 0, 0);
        step(1, 5, 8'hDA, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'hDA, 0, 0);
        step(0, 0, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hFF, 0, 0); #3 chk("rr hold rel_wid", rel_wid, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hFF, 1, 0); #3 chk("rr order rel_wid", rel_wid, ord[i]);
        end
        step(0, 0, 8'hFF, 1, 0); #3 chk("rr all released", rel_valid, 0);

        // Drain request while warp 4 waits on its pending instructions.
        step(1, 4, 8'hEF, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'hEF, 1, 1); #3 chk("drain blocked by WAIT", drain_done, 0);
        end
        step(0, 0, 8'hFF, 1, 1);
        step(0, 0, 8'hFF, 0, 1);
        step(0, 0, 8'hFF, 0, 1); #3 chk("drain_done set", drain_done, 1);
        step(0, 0, 8'hFF, 1, 0);
        step(0, 0, 8'hFF, 1, 0); #3 chk("drain_done cleared", drain_done, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'hFF, 1, 0);

        // Async reset in the middle of warp 6's settle window.
        step(1, 6, 8'hFF, 1, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'hFF, 1, 0); #3 chk("post-reset rel_valid", rel_valid, 0);
        end

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, N - 1),
                 N'($urandom | $urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 30; i++) step(0, 0, 8'hFF, 1, 0);
        #5;
        chk("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
